// File: rtl/step_ctrl.sv
// ---------------------------------------------------------------------------
// step_ctrl -- clock-step controller for the single-cycle processor board.
//
// This block replaces the free-running divided clock as the advance source of
// the core. It turns two raw push buttons into clean one-cycle step pulses.
// In manual mode each accepted press of the step button gives one pulse. In
// auto-run mode a pulse is issued every RUN_DIV cycles. step_o drives the
// clock enable of the PC/core domain; run_o drives a board LED.
//
// Parameters:
//   DEB_CYCLES  consecutive stable cycles needed to accept a button change (>= 2)
//   RUN_DIV     clk_i cycles between auto-run steps (>= 2)
//
// Ports:
//   clk_i       in   1   board clock
//   rst_ni      in   1   asynchronous active-low reset
//   btn_step_i  in   1   raw step button, asynchronous, 1 = pressed
//   btn_mode_i  in   1   raw mode button, asynchronous, 1 = pressed
//   step_o      out  1   registered one-cycle advance pulse
//   run_o       out  1   1 = auto-run mode, 0 = manual mode
//   step_cnt_o  out  32  number of steps issued
//
// Build option:
//   STEP_COUNT_EN  when defined, step_cnt_o is a free-running 32-bit count of
//                  issued steps (wraps, cleared by reset only). When undefined
//                  the counter is not built and step_cnt_o reads 32'h0; the
//                  port list is identical in both builds.
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// step_ctrl_debounce -- two-flop synchronizer, debouncer and rise detector
// for one button.
//
// Ports:
//   clk_i   in   1   board clock
//   rst_ni  in   1   asynchronous active-low reset
//   btn_i   in   1   raw asynchronous button level
//   rise_o  out  1   one-cycle strobe when the debounced level goes 0 -> 1
// ---------------------------------------------------------------------------
module step_ctrl_debounce #(
    parameter int DEB_CYCLES = 500000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic rise_o
);

    localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

    logic [1:0]    sync_q;   // [0] first flop, [1] synchronized level
    logic          sync_lvl;
    logic [CW-1:0] cnt_q;
    logic          lvl_q;
    logic          lvl_d_q;

    assign sync_lvl = sync_q[1];

    // NOTE: every register here, synchronizer flops included, is cleared by
    // reset. A button held through reset release is therefore seen as a fresh
    // 0 -> 1 change and is accepted as a press once it has been stable long
    // enough.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            lvl_q   <= 1'b0;
            lvl_d_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every right-hand
            // side reads the value from before this edge and the statement
            // order inside the block does not matter.
            sync_q  <= {sync_q[0], btn_i};
            lvl_d_q <= lvl_q;
            // The counter only advances while the synchronized level disagrees
            // with the accepted level. Any agreeing sample restarts it, so a
            // glitch shorter than DEB_CYCLES cycles never reaches lvl_q.
            if (sync_lvl == lvl_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_MAX) begin
                lvl_q <= sync_lvl;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign rise_o = lvl_q & ~lvl_d_q;

endmodule


module step_ctrl #(
    parameter int DEB_CYCLES = 500000,
    parameter int RUN_DIV    = 50000000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        btn_step_i,
    input  logic        btn_mode_i,
    output logic        step_o,
    output logic        run_o,
    output logic [31:0] step_cnt_o
);

    localparam int RW = (RUN_DIV > 2) ? $clog2(RUN_DIV) : 1;
    localparam logic [RW-1:0] RATE_MAX = RW'(RUN_DIV - 1);

    typedef enum logic {
        MANUAL = 1'b0,
        RUN    = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] rate_q, rate_d;
    logic          step_q, step_d;
    logic          step_rise;
    logic          mode_rise;

    // ------------------------------------------------------------------
    // Button conditioning
    // ------------------------------------------------------------------
    step_ctrl_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_deb_step (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .btn_i  (btn_step_i),
        .rise_o (step_rise)
    );

    step_ctrl_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_deb_mode (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .btn_i  (btn_mode_i),
        .rise_o (mode_rise)
    );

    // ------------------------------------------------------------------
    // Mode FSM, rate counter and step pulse: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written below gets a default first, so no path
        // through the case leaves one unassigned and no latch is inferred.
        state_d = state_q;
        rate_d  = '0;
        step_d  = 1'b0;

        unique case (state_q)
            MANUAL: begin
                // A mode rise in the same cycle as a step rise wins: the mode
                // changes and the step press is dropped. rate_d stays 0, so
                // the first auto step comes a full RUN_DIV cycles after entry.
                if (mode_rise) begin
                    state_d = RUN;
                end else if (step_rise) begin
                    step_d = 1'b1;
                end
            end
            RUN: begin
                // The step button is ignored here. Leaving clears the rate
                // counter and suppresses any pulse that was due this cycle.
                if (mode_rise) begin
                    state_d = MANUAL;
                end else if (rate_q == RATE_MAX) begin
                    step_d = 1'b1;
                end else begin
                    rate_d = rate_q + RW'(1);
                end
            end
            default: begin
                state_d = MANUAL;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= MANUAL;
            rate_q  <= '0;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rate_q  <= rate_d;
            step_q  <= step_d;
        end
    end

    assign step_o = step_q;
    assign run_o  = (state_q == RUN);

    // ------------------------------------------------------------------
    // Optional step counter for the 7-segment debug display
    // ------------------------------------------------------------------
`ifdef STEP_COUNT_EN
    logic [31:0] step_cnt_q;

    // Counts the registered pulse, so the count moves the cycle after step_o
    // is high. Wraps from 0xFFFFFFFF to 0; only reset clears it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            step_cnt_q <= '0;
        end else if (step_q) begin
            step_cnt_q <= step_cnt_q + 32'd1;
        end
    end

    assign step_cnt_o = step_cnt_q;
`else
    assign step_cnt_o = 32'h0;
`endif

endmodule
